// File: rtl/piso_stream_ser_pkg.sv
// Shared types and constants for the parallel-in/serial-out stream serializer.
// Pulled in by the bit selector and by the top-level controller.
package piso_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  localparam logic ORDER_LSB = 1'b0;
  localparam logic ORDER_MSB = 1'b1;

endpackage

// File: rtl/piso_stream_ser_if.sv
// Load-side and serial-side handshake bundle for piso_stream_ser.
// The master modport is the producer/consumer side; the slave modport is the serializer.
interface piso_stream_ser_if #(
  parameter int WIDTH = 8
);

  logic             ld_valid;
  logic             ld_ready;
  logic [WIDTH-1:0] pa_in;
  logic             msb_first;
  logic             se_ready;
  logic             se_out;
  logic             se_valid;
  logic             se_last;
  logic             busy;

  modport master (
    output ld_valid, pa_in, msb_first, se_ready,
    input  ld_ready, se_out, se_valid, se_last, busy
  );

  modport slave (
    input  ld_valid, pa_in, msb_first, se_ready,
    output ld_ready, se_out, se_valid, se_last, busy
  );

endinterface

// File: rtl/piso_stream_ser_bit_sel.sv
// Combinational bit picker: returns the idx-th bit of word in the requested order.
// Used both for the first bit of a freshly loaded word and for each following bit.
module piso_bit_sel
  import piso_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] word,
  input  logic [CNT_W-1:0] idx,
  input  logic             order,
  output logic             bit_out
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] pos;

  always_comb begin
    pos     = (order == ORDER_MSB) ? (LAST_IDX - idx) : idx;
    bit_out = word[pos];
  end

endmodule

// File: rtl/piso_stream_ser.sv
// Parallel-in/serial-out serializer with valid/ready on both sides.
// The word is held intact and indexed by a bit counter; the last beat may overlap the next load.
module piso_stream_ser
  import piso_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input logic             clk,
  input logic             rst,
  piso_stream_ser_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic             order_reg, order_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             se_out_reg, se_out_next;
  logic             se_valid_reg, se_valid_next;
  logic             se_last_reg, se_last_next;

  logic             ld_ready;
  logic             accept;
  logic             first_bit;
  logic             next_bit;
  logic [CNT_W-1:0] cnt_inc;

  // The final bit being consumed frees the word register for a same-cycle reload.
  assign ld_ready = (state_reg == ST_IDLE) || (se_valid_reg && se_last_reg && bus.se_ready);
  assign accept   = bus.ld_valid && ld_ready;
  assign cnt_inc  = cnt_reg + CNT_W'(1);

  piso_bit_sel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_first_sel (
    .word    (bus.pa_in),
    .idx     ('0),
    .order   (bus.msb_first),
    .bit_out (first_bit)
  );

  piso_bit_sel #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_next_sel (
    .word    (shift_reg),
    .idx     (cnt_inc),
    .order   (order_reg),
    .bit_out (next_bit)
  );

  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    order_next    = order_reg;
    cnt_next      = cnt_reg;
    se_out_next   = se_out_reg;
    se_valid_next = se_valid_reg;
    se_last_next  = se_last_reg;

    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          state_next    = ST_SHIFT;
          shift_next    = bus.pa_in;
          order_next    = bus.msb_first;
          cnt_next      = '0;
          se_out_next   = first_bit;
          se_valid_next = 1'b1;
          se_last_next  = 1'b0;
        end
      end
      ST_SHIFT: begin
        if (bus.se_ready) begin
          if (cnt_reg != LAST_IDX) begin
            cnt_next     = cnt_inc;
            se_out_next  = next_bit;
            se_last_next = (cnt_inc == LAST_IDX);
          end else if (accept) begin
            shift_next    = bus.pa_in;
            order_next    = bus.msb_first;
            cnt_next      = '0;
            se_out_next   = first_bit;
            se_valid_next = 1'b1;
            se_last_next  = 1'b0;
          end else begin
            state_next    = ST_IDLE;
            se_out_next   = 1'b0;
            se_valid_next = 1'b0;
            se_last_next  = 1'b0;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      order_reg    <= ORDER_LSB;
      cnt_reg      <= '0;
      se_out_reg   <= 1'b0;
      se_valid_reg <= 1'b0;
      se_last_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      order_reg    <= order_next;
      cnt_reg      <= cnt_next;
      se_out_reg   <= se_out_next;
      se_valid_reg <= se_valid_next;
      se_last_reg  <= se_last_next;
    end
  end

  assign bus.ld_ready = ld_ready;
  assign bus.se_out   = se_out_reg;
  assign bus.se_valid = se_valid_reg;
  assign bus.se_last  = se_last_reg;
  assign bus.busy     = (state_reg == ST_SHIFT);

endmodule
